// File: rtl/rf_pkg.sv
// Shared definitions for the register-file arbiter: width defaults, FSM state
// encoding, the last read-only register index and an index-width helper.
package rf_pkg;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned AW_DEF     = 4;
  // Registers 0..RF_RO_LAST are read-only when write protection is built in.
  localparam int unsigned RF_RO_LAST = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } state_e;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first requester at or above ptr_i, wrapping around.
module rr_pick
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   winner_o,
  output logic            valid_o
);

  logic [IW-1:0] idx;

  // Scan NREQ positions starting at ptr_i; the first hit wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/rf_arb.sv
// Round-robin arbiter giving NREQ requesters access to a single register-file
// port. Each transaction runs IDLE -> ISSUE -> DONE (three cycles).
// Optional feature: define RF_ARB_WRPROT_EN to reject writes to registers
// 0..RF_RO_LAST (gnt/done still pulse, err pulses in DONE, port stays idle).
module rf_arb
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic [DW-1:0]      rdata_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               rf_enb_o,
  output logic               rf_r_w_o,
  output logic [AW-1:0]      rf_sel_o,
  output logic [DW-1:0]      rf_in_o,
  input  logic [DW-1:0]      rf_out_i
);

  localparam int unsigned IW = idx_width(NREQ);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q;
  logic          we_q;
  logic          prot_q;
  logic [DW-1:0] rdata_q;
  logic          rf_r_w_q;
  logic [AW-1:0] rf_sel_q;
  logic [DW-1:0] rf_in_q;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          pick_we;
  logic          pick_prot;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;
  logic          latch_en;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  assign pick_we    = we_i[pick_idx];
  assign pick_addr  = addr_i[pick_idx*AW +: AW];
  assign pick_wdata = wdata_i[pick_idx*DW +: DW];

`ifdef RF_ARB_WRPROT_EN
  assign pick_prot = pick_we && (pick_addr <= AW'(RF_RO_LAST));
`else
  assign pick_prot = 1'b0;
`endif

  // Next state; requests are only looked at while idle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d  = StIssue;
          ptr_d    = IW'((32'(pick_idx) + 32'd1) % NREQ);
          latch_en = 1'b1;
        end
      end
      StIssue: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, pointer and latched request; a rejected write leaves the port untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      prot_q   <= 1'b0;
      rf_r_w_q <= 1'b1;
      rf_sel_q <= '0;
      rf_in_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (latch_en) begin
        win_q  <= pick_idx;
        we_q   <= pick_we;
        prot_q <= pick_prot;
        if (!pick_prot) begin
          rf_r_w_q <= ~pick_we;
          rf_sel_q <= pick_addr;
          rf_in_q  <= pick_wdata;
        end
      end
    end
  end

  // Read data is taken from the register file as ISSUE ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_q == StIssue && !we_q) begin
      rdata_q <= rf_out_i;
    end
  end

  // Handshake pulses and port enable, decoded from the current state.
  always_comb begin
    gnt_o    = '0;
    done_o   = '0;
    rf_enb_o = 1'b0;
    if (state_q == StIssue) begin
      gnt_o[win_q] = 1'b1;
      rf_enb_o     = ~prot_q;
    end
    if (state_q == StDone) begin
      done_o[win_q] = 1'b1;
    end
  end

`ifdef RF_ARB_WRPROT_EN
  assign err_o = (state_q == StDone) && prot_q;
`else
  assign err_o = 1'b0;
`endif

  assign busy_o   = (state_q != StIdle);
  assign rdata_o  = rdata_q;
  assign rf_r_w_o = rf_r_w_q;
  assign rf_sel_o = rf_sel_q;
  assign rf_in_o  = rf_in_q;

endmodule

// File: tb/tb_rf_arb.sv
// Scoreboard bench for rf_arb: a transaction-level model predicts grants and
// completions; a monitor compares DUT outputs every cycle.
module tb_rf_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 4;
`ifdef RF_ARB_WRPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  typedef struct {
    int unsigned   win;
    bit            we;
    bit            prot;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] rd;
    int unsigned   cyc;
  } txn_t;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_v, we_v;
  logic [NREQ*AW-1:0] addr_v;
  logic [NREQ*DW-1:0] wdata_v;
  logic [NREQ-1:0]    gnt_o, done_o;
  logic [DW-1:0]      rdata_o;
  logic               err_o, busy_o, rf_enb_o, rf_r_w_o;
  logic [AW-1:0]      rf_sel_o;
  logic [DW-1:0]      rf_in_o;
  logic [DW-1:0]      rf_out_v;

  rf_arb #(
    .NREQ (NREQ),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_v),
    .we_i     (we_v),
    .addr_i   (addr_v),
    .wdata_i  (wdata_v),
    .gnt_o    (gnt_o),
    .done_o   (done_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .busy_o   (busy_o),
    .rf_enb_o (rf_enb_o),
    .rf_r_w_o (rf_r_w_o),
    .rf_sel_o (rf_sel_o),
    .rf_in_o  (rf_in_o),
    .rf_out_i (rf_out_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Register file environment and the model's view of its contents.
  logic [DW-1:0] rf_mem  [16];
  logic [DW-1:0] ref_mem [16];

  initial begin
    rf_out_v = '0;
    for (int a = 0; a < 16; a++) begin
      rf_mem[a]  = DW'($urandom);
      ref_mem[a] = rf_mem[a];
    end
    forever begin
      @(negedge clk);
      if (rst_n && rf_enb_o) begin
        if (!rf_r_w_o) rf_mem[rf_sel_o] = rf_in_o;
        else           rf_out_v = rf_mem[rf_sel_o];
      end
    end
  end

  // Reference model: one transaction per three cycles, round-robin by search.
  txn_t gq[$];
  txn_t dq[$];
  int   m_ptr, m_cnt, m_w, m_j;
  txn_t m_t;

  initial begin
    m_ptr = 0;
    m_cnt = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        gq.delete();
        dq.delete();
        m_ptr = 0;
        m_cnt = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end else begin
        m_w = -1;
        for (int k = 0; k < NREQ; k++) begin
          m_j = (m_ptr + k) % NREQ;
          if (m_w < 0 && req_v[m_j]) m_w = m_j;
        end
        if (m_w >= 0) begin
          m_t.win  = m_w;
          m_t.we   = we_v[m_w];
          m_t.addr = addr_v[m_w*AW +: AW];
          m_t.data = wdata_v[m_w*DW +: DW];
          m_t.prot = PROT_EN && m_t.we && (m_t.addr < 5);
          m_t.rd   = ref_mem[m_t.addr];
          if (m_t.we && !m_t.prot) ref_mem[m_t.addr] = m_t.data;
          m_t.cyc = cyc + 1;
          gq.push_back(m_t);
          m_t.cyc = cyc + 2;
          dq.push_back(m_t);
          m_ptr = (m_w + 1) % NREQ;
          m_cnt = 2;
        end
      end
    end
  end

  // Monitor: compare every cycle against what the model queued for it.
  logic [NREQ-1:0] e_gnt, e_done;
  logic            e_enb, e_err, l_rw;
  logic [AW-1:0]   l_sel;
  logic [DW-1:0]   l_in, e_rdata;
  bit              have_g, have_d;
  txn_t            tg, td;

  initial begin
    l_rw = 1'b1; l_sel = '0; l_in = '0; e_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        l_rw = 1'b1; l_sel = '0; l_in = '0; e_rdata = '0;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_rf_enb", rf_enb_o, 0);
        chk("rst_rf_r_w", rf_r_w_o, 1);
        chk("rst_rf_sel", rf_sel_o, 0);
        chk("rst_rf_in", rf_in_o, 0);
      end else begin
        e_gnt = '0; e_done = '0; e_enb = 1'b0; e_err = 1'b0;
        have_g = 0; have_d = 0;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          tg = gq.pop_front();
          have_g = 1;
          e_gnt[tg.win] = 1'b1;
          if (!tg.prot) begin
            e_enb = 1'b1; l_rw = !tg.we; l_sel = tg.addr; l_in = tg.data;
          end
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          td = dq.pop_front();
          have_d = 1;
          e_done[td.win] = 1'b1;
          e_err = td.prot;
          if (!td.we) e_rdata = td.rd;
        end
        chk("gnt", gnt_o, e_gnt);
        chk("done", done_o, e_done);
        chk("busy", busy_o, have_g || have_d);
        chk("rf_enb", rf_enb_o, e_enb);
        chk("rf_r_w", rf_r_w_o, l_rw);
        chk("rf_sel", rf_sel_o, l_sel);
        chk("rf_in", rf_in_o, l_in);
        chk("rdata", rdata_o, e_rdata);
        chk("err", err_o, e_err);
      end
    end
  end

  // Wait (bounded) for a grant to any requester in mask; returns at a negedge.
  task automatic wait_gnt(input logic [NREQ-1:0] mask);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((gnt_o & mask) != 0) got = 1;
    end
    chk("gnt_seen", got, 1);
  endtask

  task automatic issue(input int i, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    req_v[i] = 1'b1;
    we_v[i]  = w;
    addr_v[i*AW +: AW]  = a;
    wdata_v[i*DW +: DW] = d;
    wait_gnt(NREQ'(1) << i);
    @(posedge clk);
    #1;
    req_v[i] = 1'b0;
  endtask

  logic [NREQ-1:0] g;

  initial begin
    rst_n = 1'b1;
    req_v = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Both requesters reading, held from reset release.
    req_v = '1;
    addr_v = {4'd9, 4'd6};
    #2 rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1 req_v = '0;
    repeat (4) @(posedge clk);

    // Write then read back on requester 0.
    issue(0, 1'b1, 4'd7, 8'hA5);
    issue(0, 1'b0, 4'd7, 8'h00);

    // Requester 1 arrives while requester 0 is in ISSUE.
    @(posedge clk);
    #1 req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[3:0] = 4'd3;
    wait_gnt(2'b01);
    #2 req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[7:4] = 4'd7;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    wait_gnt(2'b10);
    @(posedge clk);
    #1 req_v[1] = 1'b0;

    // Write to a low register, then read it back.
    issue(1, 1'b1, 4'd2, 8'h3C);
    issue(1, 1'b0, 4'd2, 8'h00);

    // Reset during ISSUE, with both requesting throughout.
    @(posedge clk);
    #1 req_v = '1; we_v = '0;
    wait_gnt(2'b11);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_gnt(2'b11);
    chk("first_gnt_after_reset", gnt_o, 2'b01);
    @(posedge clk);
    #1 req_v = '0;
    repeat (4) @(posedge clk);

    // Random traffic, including abandoned requests.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      g = gnt_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) req_v[i] = 1'b0;
        if (!req_v[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_v[i] = 1'b1;
            we_v[i]  = 1'($urandom);
            addr_v[i*AW +: AW]  = AW'($urandom_range(0, 15));
            wdata_v[i*DW +: DW] = DW'($urandom);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          req_v[i] = 1'b0;
        end
      end
    end
    #1 req_v = '0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", gq.size() + dq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
